ssd_scan_driver: RTL and testbench

- Consumes the 16-bit packed BCD value produced by the counter/BCD path and drives the Basys 3 4-digit common-anode seven-segment display.
- Time-multiplexes the four digits with a refresh prescaler and inter-digit ghost blanking.
- Latches the BCD input once per frame so the display never tears, and applies leading-zero blanking.
- Sits between the BCD source and the top-level an/seg/dp pins.

---
 rtl/ssd_pkg.sv | 44 ++++
 rtl/ssd_scan_driver_bcd_to_seg7.sv | 33 +++
 rtl/ssd_scan_driver.sv | 101 ++++++++++
 tb/tb_ssd_scan_driver.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
//------------------------------------------------------------------------------
// ssd_pkg: shared constants and helpers for the 4-digit seven-segment driver.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ssd_pkg;

    localparam int DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    localparam logic [6:0]        SEG_OFF = 7'h7F;
    localparam logic [DIGITS-1:0] AN_OFF  = 4'hF;

    // A digit is a leading zero when it and every more-significant nibble are
    // zero; digit 0 never qualifies, and a lit decimal point keeps it visible.
    function automatic logic digit_lz_blank(input logic [15:0]       bcd,
                                            input logic [DIGITS-1:0] dpv,
                                            input digit_idx_t        idx);
        logic [DIGITS-1:0] zero_from;
        zero_from[3] = (bcd[15:12] == 4'h0);
        zero_from[2] = zero_from[3] & (bcd[11:8] == 4'h0);
        zero_from[1] = zero_from[2] & (bcd[7:4]  == 4'h0);
        zero_from[0] = 1'b0;
        return zero_from[idx] & ~dpv[idx];
    endfunction

endpackage : ssd_pkg

`default_nettype wire

// File: rtl/ssd_scan_driver_bcd_to_seg7.sv
//------------------------------------------------------------------------------
// bcd_to_seg7: combinational BCD nibble to active-low segment pattern.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_to_seg7
    import ssd_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule : bcd_to_seg7

`default_nettype wire

// File: rtl/ssd_scan_driver.sv
//------------------------------------------------------------------------------
// ssd_scan_driver: multiplexed common-anode 4-digit display driver with
// frame-latched input, ghost blanking and leading-zero suppression.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int LZ_BLANK     = 1
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              enable,
    input  logic [15:0]       bcd_in,
    input  logic [DIGITS-1:0] dp_in,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              frame_tick
);

    localparam int              PW      = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]   P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]   P_BLANK = PW'(BLANK_CYCLES);

    logic [PW-1:0]       p_q, p_d;
    digit_idx_t          idx_q, idx_d;
    logic [15:0]         shadow_bcd_q, shadow_bcd_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                frame_tick_q, frame_tick_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;

    logic                slot_end;
    logic                frame_latch;
    logic                lz_blank;
    logic                lit;
    logic [3:0]          nibble;
    logic [6:0]          seg_pattern;

    bcd_to_seg7 u_bcd_to_seg7 (
        .nibble_i (nibble),
        .seg_o    (seg_pattern)
    );

    always_comb begin
        slot_end    = (p_q == P_LAST);
        frame_latch = slot_end && (idx_q == 2'd3);

        p_d   = slot_end ? '0 : p_q + 1'b1;
        idx_d = slot_end ? idx_q + 2'd1 : idx_q;

        shadow_bcd_d = frame_latch ? bcd_in : shadow_bcd_q;
        shadow_dp_d  = frame_latch ? dp_in  : shadow_dp_q;
        frame_tick_d = frame_latch;

        // Outputs track the current scan state, so they lag it by one cycle
        nibble   = shadow_bcd_q[{idx_q, 2'b00} +: 4];
        lz_blank = (LZ_BLANK != 0) && digit_lz_blank(shadow_bcd_q, shadow_dp_q, idx_q);
        lit      = enable && (p_q >= P_BLANK) && !lz_blank;

        an_d  = lit ? ~(4'b0001 << idx_q) : AN_OFF;
        seg_d = lit ? seg_pattern : SEG_OFF;
        dp_d  = lit ? ~shadow_dp_q[idx_q] : 1'b1;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            p_q          <= '0;
            idx_q        <= 2'd0;
            shadow_bcd_q <= 16'h0000;
            shadow_dp_q  <= 4'h0;
            frame_tick_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
        end else begin
            p_q          <= p_d;
            idx_q        <= idx_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            frame_tick_q <= frame_tick_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule : ssd_scan_driver

`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
//------------------------------------------------------------------------------
// tb_ssd_scan_driver: directed and randomized checks of ssd_scan_driver against
// a cycle-count based model of the display.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ssd_scan_driver;

    localparam int RDIV  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * RDIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] bcd_in = 16'h1234;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;

    // Model state: edges since reset release and the value the display holds
    int          m_k = 0;
    logic [15:0] m_bcd = 16'h0000;
    logic [3:0]  m_dp  = 4'h0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    ssd_scan_driver #(
        .REFRESH_DIV  (RDIV),
        .BLANK_CYCLES (BLANK),
        .LZ_BLANK     (1)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .enable     (enable),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at k=%0d: observed=%0h expected=%0h", tag, m_k, obs, exp);
        end
    endtask

    // What the pins must show during model cycle k for a held value and enable
    task automatic model_out(input int k, input logic [15:0] bcd, input logic [3:0] dpv,
                             input logic en, output logic [3:0] e_an,
                             output logic [6:0] e_seg, output logic e_dp);
        int          slot;
        int          pos;
        logic [15:0] upper;
        logic        lz;
        slot  = (k / RDIV) % 4;
        pos   = k % RDIV;
        upper = bcd >> (4 * slot);
        lz    = (slot != 0) && (upper == 16'h0) && !dpv[slot];
        if (en && pos >= BLANK && !lz) begin
            e_an  = 4'hF & ~(4'h1 << slot);
            e_seg = seg_tab[upper[3:0]];
            e_dp  = ~dpv[slot];
        end else begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end
    endtask

    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       latch;
        model_out(m_k, m_bcd, m_dp, enable, e_an, e_seg, e_dp);
        latch = ((m_k % FRAME) == FRAME - 1);
        @(posedge clk);
        if (latch) begin
            m_bcd = bcd_in;
            m_dp  = dp_in;
        end
        m_k++;
        #1;
        chk("an",         {12'h0, an},         {12'h0, e_an});
        chk("seg",        {9'h0, seg},         {9'h0, e_seg});
        chk("dp",         {15'h0, dp},         {15'h0, e_dp});
        chk("frame_tick", {15'h0, frame_tick}, {15'h0, latch});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("rst_an",    {12'h0, an},         16'h000F);
            chk("rst_seg",   {9'h0, seg},         16'h007F);
            chk("rst_dp",    {15'h0, dp},         16'h0001);
            chk("rst_ftick", {15'h0, frame_tick}, 16'h0000);
        end
        reset = 1'b0;
        m_k   = 0;
        m_bcd = 16'h0000;
        m_dp  = 4'h0;
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int d = 0; d < 4; d++)
            v[4*d +: 4] = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 0));
        return v;
    endfunction

    initial begin
        // Reset with a nonzero input present
        do_reset(5);

        // First frame shows the reset shadow "0"; second frame shows 1234
        run(FRAME + RDIV + 3);
        bcd_in = 16'h5678;   // mid-frame while digit 1 is lit: must not tear
        run(FRAME - RDIV - 3 + 2 * FRAME);

        bcd_in = 16'h0050;
        run(2 * FRAME);
        dp_in = 4'b0100;
        run(2 * FRAME);

        dp_in  = 4'h0;
        bcd_in = 16'h9A0F;
        run(2 * FRAME);
        enable = 1'b0;
        run(20);
        enable = 1'b1;
        run(2 * FRAME);

        dp_in  = 4'b0001;
        bcd_in = 16'h9999;
        run(2 * FRAME);

        // Long randomized scan with input churn and enable glitches
        for (int f = 0; f < 1000; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                if ($urandom_range(15, 0) == 0) begin
                    bcd_in = rand_bcd();
                    dp_in  = 4'($urandom_range(15, 0)) & 4'($urandom_range(15, 0));
                end
                if ($urandom_range(63, 0) == 0) enable = ~enable;
                step();
            end
        end
        enable = 1'b1;

        // Reset mid-frame while a digit is lit
        bcd_in = 16'h4321;
        run(FRAME + 2 * RDIV + 4);
        do_reset(1);
        run(2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ssd_scan_driver

`default_nettype wire
